mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, data-memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive VGA grants tolerated while cpu_req is pending.
REQ-004 SHALL have port clk, input, 1, single clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port vga_en, input, 1, enables VGA requester; when 0, vga_req is ignored.
REQ-007 SHALL have ports cpu_req / cpu_we, input, 1 each, CPU access request / write qualifier.
REQ-008 SHALL have ports cpu_addr [ADDR_W] and cpu_wdata [DATA_W], input, CPU address / write data.
REQ-009 SHALL have ports cpu_ack, output, 1, and cpu_rdata, output, [DATA_W], CPU completion pulse / read data.
REQ-010 SHALL have ports vga_req, input, 1, and vga_addr, input, [ADDR_W], read-only VGA fetch request / pixel address.
REQ-011 SHALL have ports vga_ack, output, 1, and vga_rdata, output, [DATA_W], VGA completion pulse / pixel data.
REQ-012 SHALL have ports mem_addr [ADDR_W], mem_we [1], mem_wdata [DATA_W], output, to the single-port RAM; and mem_rdata [DATA_W], input, RAM read data, 1-cycle registered read.
REQ-013 SHALL have port owner, output, 2, current owner: 00 none, 01 CPU, 10 VGA.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on any eligible request, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 Arbitration happens only in IDLE; winner and its addr/we/wdata are registered onto mem_* at the IDLE->ACCESS edge.
REQ-016 Priority: VGA (vga_req & vga_en) beats CPU, except as modified by REQ-027.
REQ-017 mem_we SHALL be 1 for exactly the ACCESS cycle of a CPU write; 0 in all other cycles; never 1 for VGA.
REQ-018 In RESP, the winner's ack SHALL pulse for exactly one cycle and its rdata SHALL load mem_rdata; the loser's rdata SHALL hold.
REQ-019 Latency: request sampled in IDLE at edge N -> ack high in cycle N+2; throughput 1 access per 3 cycles.
REQ-020 Requesters SHALL hold req/addr/data until ack; req still high in the cycle after ack is a new request.
REQ-021 A req dropped mid-transaction SHALL NOT abort; the access completes and ack still pulses.
REQ-022 vga_en falling during a VGA transaction SHALL NOT abort it.
REQ-023 Simultaneous eligible requests: exactly one grant per transaction; the loser stays pending, no ack.
REQ-024 owner SHALL equal the registered winner during ACCESS and RESP, and 00 in IDLE.
REQ-025 cpu_rdata after a CPU write SHALL equal mem_rdata at RESP; no meaning is guaranteed.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, mem_addr=0, mem_we=0, mem_wdata=0, cpu_ack=vga_ack=0, cpu_rdata=vga_rdata=0, owner=00, starvation counter=0, including mid-transaction; the in-flight access is dropped without ack.

Configuration
REQ-027 With macro MEM_ARB_STARVE_GUARD_EN defined, a counter SHALL count VGA grants while cpu_req is high. When it reaches STARVE_LIMIT, the next arbitration SHALL grant the CPU if cpu_req is high. The counter SHALL clear on any CPU grant or whenever cpu_req is low in IDLE.
REQ-028 Without MEM_ARB_STARVE_GUARD_EN, no counter SHALL be built and strict VGA priority SHALL apply.

Verification
REQ-029 CPU write: cpu_req=1, cpu_we=1, addr=0x00010, wdata=0xA5, vga_req=0 -> mem_we=1 for one cycle with mem_addr=0x00010 and mem_wdata=0xA5; cpu_ack at +2; owner=01.
REQ-030 CPU read-back: cpu_req=1, cpu_we=0, addr=0x00010; RAM returns 0xA5 -> cpu_rdata=0xA5 with cpu_ack at +2; vga_rdata unchanged.
REQ-031 Contention: cpu_req and vga_req both high with vga_en=1 -> VGA granted first, vga_ack; then CPU granted, cpu_ack 3 cycles later.
REQ-032 vga_en=0 with vga_req=1 -> no VGA grant; owner stays 00 when cpu_req=0.
REQ-033 Starvation (macro on, STARVE_LIMIT=4): vga_req and cpu_req held high -> 4 vga_acks, then a cpu_ack, then VGA resumes; with macro off, no cpu_ack ever.
REQ-034 Reset mid-write: rst_n low during ACCESS of a CPU write -> mem_we=0 asynchronously; no cpu_ack; all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// CPU / VGA / RAM bundle for mem_port_arbiter.
// The arbiter takes the slave side; requesters and the RAM take master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              vga_en;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;

  modport master (
    output vga_en, cpu_req, cpu_we,
    output cpu_addr, cpu_wdata,
    output vga_req, vga_addr,
    output mem_rdata,
    input  cpu_ack, cpu_rdata,
    input  vga_ack, vga_rdata,
    input  mem_addr, mem_we,
    input  mem_wdata, owner
  );

  modport slave (
    input  vga_en, cpu_req, cpu_we,
    input  cpu_addr, cpu_wdata,
    input  vga_req, vga_addr,
    input  mem_rdata,
    output cpu_ack, cpu_rdata,
    output vga_ack, vga_rdata,
    output mem_addr, mem_we,
    output mem_wdata, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter, VGA over CPU, 3-cycle IDLE/ACCESS/RESP access.
// Define MEM_ARB_STARVE_GUARD_EN to add the CPU starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_VGA  = 2'b10;

  state_t            state;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_ack;
  logic              vga_ack;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vga_rdata_q;

  logic vga_elig;
  logic starve;
  logic grant_cpu;
  logic grant_vga;

  assign vga_elig  = bus.vga_req & bus.vga_en;
  assign grant_cpu = bus.cpu_req & (~vga_elig | starve);
  assign grant_vga = vga_elig & ~grant_cpu;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign starve = (starve_cnt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!bus.cpu_req || grant_cpu)
        starve_cnt <= '0;
      else if (grant_vga && !starve)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  wire unused_starve_limit = |STARVE_LIMIT;

  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      vga_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      cpu_ack <= 1'b0;
      vga_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_cpu) begin
            state     <= ACCESS;
            owner     <= OWN_CPU;
            mem_addr  <= bus.cpu_addr;
            mem_we    <= bus.cpu_we;
            mem_wdata <= bus.cpu_wdata;
          end else if (grant_vga) begin
            state     <= ACCESS;
            owner     <= OWN_VGA;
            mem_addr  <= bus.vga_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
          end
        end
        ACCESS: begin
          state   <= RESP;
          mem_we  <= 1'b0;
          cpu_ack <= (owner == OWN_CPU);
          vga_ack <= (owner == OWN_VGA);
        end
        RESP: begin
          state <= IDLE;
          owner <= OWN_NONE;
          if (owner == OWN_CPU)
            cpu_rdata_q <= bus.mem_rdata;
          if (owner == OWN_VGA)
            vga_rdata_q <= bus.mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data is only valid in RESP, so pass it through then and hold after.
  logic cpu_resp;
  logic vga_resp;

  assign cpu_resp = (state == RESP) && (owner == OWN_CPU);
  assign vga_resp = (state == RESP) && (owner == OWN_VGA);

  assign bus.cpu_rdata = cpu_resp ? bus.mem_rdata : cpu_rdata_q;
  assign bus.vga_rdata = vga_resp ? bus.mem_rdata : vga_rdata_q;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.vga_ack   = vga_ack;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;
  assign bus.owner     = owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle registered RAM model.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [256];

  always @(posedge clk) begin
    if (!rst_n)
      ram[8'h20] <= 8'h5A;
    else if (bus.mem_we)
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_owner"}, 32'(bus.owner), 0);
    chk({tag, "_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_cack"}, 32'(bus.cpu_ack), 0);
    chk({tag, "_vack"}, 32'(bus.vga_ack), 0);
    chk({tag, "_crd"}, 32'(bus.cpu_rdata), 0);
    chk({tag, "_vrd"}, 32'(bus.vga_rdata), 0);
  endtask

  int nv_before;
  int nv_after;
  int ncpu;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.vga_en    = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;

    cyc(1);
    chk_reset_outs("rst");
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // CPU write of 0xA5 to 0x10
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h00010;
    bus.cpu_wdata = 8'hA5;
    cyc(1);
    chk("wr_acc_we", 32'(bus.mem_we), 1);
    chk("wr_acc_addr", 32'(bus.mem_addr), 32'h10);
    chk("wr_acc_wdata", 32'(bus.mem_wdata), 32'hA5);
    chk("wr_acc_owner", 32'(bus.owner), 1);
    chk("wr_acc_ack", 32'(bus.cpu_ack), 0);
    cyc(1);
    chk("wr_resp_ack", 32'(bus.cpu_ack), 1);
    chk("wr_resp_we", 32'(bus.mem_we), 0);
    chk("wr_resp_owner", 32'(bus.owner), 1);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    cyc(1);
    chk("wr_idle_ack", 32'(bus.cpu_ack), 0);
    chk("wr_idle_owner", 32'(bus.owner), 0);

    // CPU read-back of 0x10
    bus.cpu_req = 1'b1;
    cyc(1);
    chk("rd_acc_we", 32'(bus.mem_we), 0);
    chk("rd_acc_owner", 32'(bus.owner), 1);
    cyc(1);
    chk("rd_resp_ack", 32'(bus.cpu_ack), 1);
    chk("rd_resp_data", 32'(bus.cpu_rdata), 32'hA5);
    chk("rd_resp_vrd", 32'(bus.vga_rdata), 0);
    bus.cpu_req = 1'b0;
    cyc(1);
    chk("rd_hold_data", 32'(bus.cpu_rdata), 32'hA5);
    chk("rd_hold_ack", 32'(bus.cpu_ack), 0);

    // Contention: VGA reads 0x20 first, CPU reads 0x10 next
    bus.vga_en   = 1'b1;
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h00020;
    bus.cpu_req  = 1'b1;
    cyc(1);
    chk("ct_acc_owner", 32'(bus.owner), 2);
    chk("ct_acc_addr", 32'(bus.mem_addr), 32'h20);
    chk("ct_acc_we", 32'(bus.mem_we), 0);
    cyc(1);
    chk("ct_vack", 32'(bus.vga_ack), 1);
    chk("ct_vdata", 32'(bus.vga_rdata), 32'h5A);
    chk("ct_cack0", 32'(bus.cpu_ack), 0);
    bus.vga_req = 1'b0;
    cyc(1);
    chk("ct_idle_owner", 32'(bus.owner), 0);
    chk("ct_vhold", 32'(bus.vga_rdata), 32'h5A);
    cyc(1);
    chk("ct_cacc_owner", 32'(bus.owner), 1);
    chk("ct_cacc_addr", 32'(bus.mem_addr), 32'h10);
    cyc(1);
    chk("ct_cack", 32'(bus.cpu_ack), 1);
    chk("ct_cdata", 32'(bus.cpu_rdata), 32'hA5);
    chk("ct_vhold2", 32'(bus.vga_rdata), 32'h5A);
    bus.cpu_req = 1'b0;
    cyc(1);

    // vga_en low masks vga_req
    bus.vga_en  = 1'b0;
    bus.vga_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("dis_owner", 32'(bus.owner), 0);
      chk("dis_vack", 32'(bus.vga_ack), 0);
    end

    // Both held: strict priority or starvation guard
    bus.vga_en  = 1'b1;
    bus.cpu_req = 1'b1;
    nv_before = 0;
    nv_after  = 0;
    ncpu      = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(1);
      if (bus.vga_ack) begin
        if (ncpu == 0) nv_before++;
        else nv_after++;
      end
      if (bus.cpu_ack) ncpu++;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("stv_vga_first", 32'(nv_before), 4);
    chk("stv_cpu_acks", 32'(ncpu), 3);
    chk("stv_vga_after", 32'(nv_after), 8);
`else
    chk("stv_vga_only", 32'(nv_before), 15);
    chk("stv_cpu_acks", 32'(ncpu), 0);
`endif
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
    cyc(3);

    // Reset asserted during ACCESS of a CPU write
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h00033;
    bus.cpu_wdata = 8'h3C;
    cyc(1);
    chk("mr_acc_we", 32'(bus.mem_we), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mr");
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("mr_no_ack", 32'(bus.cpu_ack), 0);
      chk("mr_owner", 32'(bus.owner), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
